// File: rtl/sample_requantizer.sv
// sample_requantizer: multi-channel requantiser that narrows wide signed
// audio samples to the codec width. It uses a 2-stage valid/ready pipeline.
//   Stage 1: clamps the shift amount, optionally rounds, then applies an
//            arithmetic right shift.
//   Stage 2: saturates to OUT_W, applies mute, and updates the per-channel
//            clip counters.
// Optional build macro: REQUANT_ROUND_EN selects round-half-up before the shift.
// Without it the design truncates and no rounding adder is built.
module sample_requantizer #(
    parameter int IN_W     = 24,
    parameter int OUT_W    = 16,
    parameter int CHANNELS = 2,
    parameter int SH_W     = 5,
    parameter int CNT_W    = 16,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enn,
    input  logic [SH_W-1:0]           shift,
    input  logic [IN_W-1:0]           in_data,
    input  logic [CH_W-1:0]           in_chan,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [CH_W-1:0]           out_chan,
    output logic                      out_clip,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      clr_clip,
    output logic [CHANNELS*CNT_W-1:0] clip_cnt
);

    // One guard bit so the rounding bias can never overflow the sum
    localparam int XW = IN_W + 1;

    // Saturation limits expressed in the stage-1 result width
    localparam logic signed [XW-1:0] MAX_V = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_V = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                   adv1;
    logic                   adv2;
    logic                   load2;

    logic                   s1_valid_reg;
    logic signed [XW-1:0]   s1_r_reg;
    logic [CH_W-1:0]        s1_chan_reg;
    logic                   s1_en_reg;

    logic                   out_valid_reg;
    logic [OUT_W-1:0]       out_data_reg;
    logic [CH_W-1:0]        out_chan_reg;
    logic                   out_clip_reg;

    logic [31:0]            shift_ext;
    logic [31:0]            s_eff;
    logic signed [XW-1:0]   x_ext;
    logic signed [XW-1:0]   x_sum;
    logic signed [XW-1:0]   r_next;
    logic [OUT_W-1:0]       data_next;
    logic                   clip_next;

    // A stage advances when it is empty or its contents are leaving
    assign adv2     = !out_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = rst_n && adv1;
    assign load2    = adv2 && s1_valid_reg;

    assign shift_ext = 32'(shift);
    assign s_eff     = (shift_ext > 32'(IN_W - 1)) ? 32'(IN_W - 1) : shift_ext;
    assign x_ext     = {in_data[IN_W-1], in_data};

`ifdef REQUANT_ROUND_EN
    logic signed [XW-1:0]   bias;

    // Half an output LSB, which is zero when there is no shift
    always_comb begin
        bias = '0;
        if (s_eff != 32'd0) begin
            bias = XW'(1) << (s_eff - 32'd1);
        end
    end

    assign x_sum = x_ext + bias;
`else
    assign x_sum = x_ext;
`endif

    assign r_next = x_sum >>> s_eff;

    // Stage 1: capture the shifted sample, its channel and mute state on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_r_reg     <= '0;
            s1_chan_reg  <= '0;
            s1_en_reg    <= 1'b0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_r_reg    <= r_next;
                s1_chan_reg <= in_chan;
                s1_en_reg   <= enn;
            end
        end
    end

    // Saturate to the output range; mute forces zero and hides the clip flag
    always_comb begin
        data_next = s1_r_reg[OUT_W-1:0];
        clip_next = 1'b0;
        if (s1_r_reg > MAX_V) begin
            data_next = MAX_V[OUT_W-1:0];
            clip_next = 1'b1;
        end else if (s1_r_reg < MIN_V) begin
            data_next = MIN_V[OUT_W-1:0];
            clip_next = 1'b1;
        end
        if (!s1_en_reg) begin
            data_next = '0;
            clip_next = 1'b0;
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_clip_reg  <= 1'b0;
        end else if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg <= data_next;
                out_chan_reg <= s1_chan_reg;
                out_clip_reg <= clip_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_clip  = out_clip_reg;

    // Per-channel clip counters. Out-of-range channel indices match no counter.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic             inc;

        assign inc = load2 && clip_next && (s1_chan_reg == CH_W'(gi));

        // Clear has priority over increment; the count sticks at all-ones
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (clr_clip) begin
                cnt_reg <= '0;
            end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign clip_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end

endmodule

// File: tb/tb_sample_requantizer.sv
// Testbench for sample_requantizer.
// Directed vectors carry hand-computed literals, and every cycle the DUT is
// also compared against an arithmetic reference model with an expected-output
// queue. Expected literals follow REQUANT_ROUND_EN when it is defined.
module tb_sample_requantizer;

    localparam int IN_W     = 24;
    localparam int OUT_W    = 16;
    localparam int CHANNELS = 2;
    localparam int SH_W     = 5;
    localparam int CNT_W    = 16;
    localparam int CH_W     = $clog2(CHANNELS);

`ifdef REQUANT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      enn = 1'b1;
    logic [SH_W-1:0]           shift = '0;
    logic [IN_W-1:0]           in_data = '0;
    logic [CH_W-1:0]           in_chan = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [OUT_W-1:0]          out_data;
    logic [CH_W-1:0]           out_chan;
    logic                      out_clip;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic                      clr_clip = 1'b0;
    logic [CHANNELS*CNT_W-1:0] clip_cnt;

    sample_requantizer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CHANNELS), .SH_W(SH_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enn(enn), .shift(shift),
        .in_data(in_data), .in_chan(in_chan), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_clip(out_clip),
        .out_valid(out_valid), .out_ready(out_ready),
        .clr_clip(clr_clip), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [CH_W-1:0]  chan;
        logic             clip;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_m[CHANNELS];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    // Reference: exact integer arithmetic on the signed sample value
    function automatic exp_t model(input logic [IN_W-1:0] d, input logic [SH_W-1:0] sh,
                                   input logic en, input logic [CH_W-1:0] ch);
        longint v;
        int     s;
        exp_t   e;
        v = longint'($signed(d));
        s = (int'(sh) > IN_W - 1) ? IN_W - 1 : int'(sh);
        if (ROUND && s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        e.chan = ch;
        e.clip = 1'b0;
        if (v > (longint'(1) << (OUT_W - 1)) - 1) begin
            e.data = {1'b0, {(OUT_W-1){1'b1}}};
            e.clip = 1'b1;
        end else if (v < -(longint'(1) << (OUT_W - 1))) begin
            e.data = {1'b1, {(OUT_W-1){1'b0}}};
            e.clip = 1'b1;
        end else begin
            e.data = v[OUT_W-1:0];
        end
        if (!en) begin
            e.data = '0;
            e.clip = 1'b0;
        end
        return e;
    endfunction

    // Compare process: samples on the falling edge, tracking the posedge just passed
    logic rst_prev = 1'b0;
    logic clr_prev = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_xfer = 1'b0;
    always @(negedge clk) begin
        logic new_s;
        int   ch;
        if (!rst_prev) begin
            exp_q.delete();
            for (int i = 0; i < CHANNELS; i++) cnt_m[i] = 0;
            chk("reset_out_valid", out_valid, 0);
            chk("reset_clip_cnt", clip_cnt, 0);
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            new_s = out_valid && (!prev_valid || prev_xfer);
            if (clr_prev) begin
                for (int i = 0; i < CHANNELS; i++) cnt_m[i] = 0;
            end else if (new_s && exp_q.size() > 0 && exp_q[0].clip) begin
                ch = int'(exp_q[0].chan);
                if (ch < CHANNELS && cnt_m[ch] < (1 << CNT_W) - 1) cnt_m[ch]++;
            end
            for (int i = 0; i < CHANNELS; i++)
                chk("clip_cnt", clip_cnt[i*CNT_W +: CNT_W], cnt_m[i]);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_chan", out_chan, exp_q[0].chan);
                    chk("out_clip", out_clip, exp_q[0].clip);
                end
            end
            prev_valid = out_valid;
            prev_xfer  = out_valid && out_ready;
            if (prev_xfer && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
        end
        if (!rst_n) chk("in_ready_in_reset", in_ready, 0);
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_data, shift, enn, in_chan));
        if (rst_n && in_valid && !in_ready) stall_cnt++;
        rst_prev = rst_n;
        clr_prev = clr_clip;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until accepted; report the cycles taken
    task automatic send(input logic [IN_W-1:0] d, input logic [CH_W-1:0] ch,
                        input logic [SH_W-1:0] sh, output int tries);
        logic acc;
        acc = 1'b0;
        tries = 0;
        in_data = d; in_chan = ch; shift = sh; in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    // Count falling edges after the accepting edge until out_valid appears
    task automatic wait_out(output int lat, output logic [OUT_W-1:0] d, output logic c);
        lat = 99; d = '0; c = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n; d = out_data; c = out_clip;
                break;
            end
        end
    endtask

    initial begin
        int               t, t_sum, lat;
        logic [OUT_W-1:0] d;
        logic             c;
        int               n_out0, stall0;

        repeat (2) tick();
        chk("reset_lit_in_ready", in_ready, 0);
        chk("reset_lit_out_valid", out_valid, 0);
        chk("reset_lit_out_data", out_data, 0);
        chk("reset_lit_clip_cnt", clip_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Basic shift by 8 and rounding of a half-up case
        send(24'h123456, 0, 8, t); wait_out(lat, d, c);
        chk("t1_latency", lat, 2); chk("t1_data_a", d, 16'h1234); chk("t1_clip_a", c, 0);
        tick();
        send(24'h1234C0, 0, 8, t); wait_out(lat, d, c);
        chk("t1_data_b", d, ROUND ? 16'h1235 : 16'h1234);
        tick();

        // Negative values
        send(24'hFFFF80, 1, 8, t); wait_out(lat, d, c);
        chk("t2_data_a", d, ROUND ? 16'h0000 : 16'hFFFF);
        tick();
        send(24'hFFFE00, 0, 8, t); wait_out(lat, d, c);
        chk("t2_data_b", d, 16'hFFFE);
        tick();

        // Saturation and clip counters
        send(24'h7FFFFF, 1, 4, t); wait_out(lat, d, c);
        chk("t3_pos_data", d, 16'h7FFF); chk("t3_pos_clip", c, 1);
        chk("t3_cnt_ch1", clip_cnt[CNT_W +: CNT_W], 1);
        tick();
        send(24'h800000, 0, 4, t); wait_out(lat, d, c);
        chk("t3_neg_data", d, 16'h8000); chk("t3_neg_clip", c, 1);
        chk("t3_cnt_ch0", clip_cnt[0 +: CNT_W], 1);
        tick();
        send(24'h7FFFFF, 1, 4, t);
        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
        @(negedge clk);
        chk("t3_clr_wins", clip_cnt, 0);
        repeat (3) tick();

        // Mute: zero data, no clip, full throughput
        enn = 1'b0;
        send(24'h7FFFFF, 1, 4, t); wait_out(lat, d, c);
        chk("t5_mute_data", d, 0); chk("t5_mute_clip", c, 0);
        tick();
        t_sum = 0;
        send(24'h7FFFFF, 1, 4, t); t_sum += t;
        send(24'h800000, 0, 4, t); t_sum += t;
        send(24'h7FFFFF, 0, 4, t); t_sum += t;
        chk("t5_rate", t_sum, 3);
        repeat (4) tick();
        chk("t5_cnt_unchanged", clip_cnt, 0);
        enn = 1'b1;

        // Backpressure mid-stream
        n_out0 = n_out; stall0 = stall_cnt;
        fork
            begin
                int tt;
                for (int i = 0; i < 6; i++) send(24'h010000 + 24'(i * 24'h300), CH_W'(i % 2), 8, tt);
            end
            begin
                repeat (2) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();
        chk("t4_out_count", n_out - n_out0, 6);
        chk("t4_in_ready_dropped", (stall_cnt > stall0) ? 1 : 0, 1);
        chk("t4_drained", exp_q.size(), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(24'h7FFFFF, 0, 4, t);
        send(24'h7FFFFF, 1, 4, t);
        rst_n = 1'b0;
        tick();
        chk("t6_out_valid", out_valid, 0);
        chk("t6_clip_cnt", clip_cnt, 0);
        chk("t6_in_ready", in_ready, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(24'h800000, 0, 31, t); wait_out(lat, d, c);
        chk("t6_latency", lat, 2); chk("t6_clamp_data", d, 16'hFFFF); chk("t6_clamp_clip", c, 0);
        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
